// File: rtl/hex_pkg.sv
// Shared types and constants for the hex display arbiter.
package hex_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DWELL = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Bits needed to hold 0..n, never less than one.
  function automatic int cnt_width(input longint unsigned n);
    int w;
    w = $clog2(n + 64'd1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/HexDriver.sv
// Nibble to active-low seven-segment glyph (gfedcba), hex digits 0-F.
module HexDriver (
  input  logic [3:0] In0,
  output logic [6:0] Out0
);

  // Glyph lookup; lowercase b and d keep them distinct from 8 and 0.
  always_comb begin
    case (In0)
      4'h0:    Out0 = 7'b1000000;
      4'h1:    Out0 = 7'b1111001;
      4'h2:    Out0 = 7'b0100100;
      4'h3:    Out0 = 7'b0110000;
      4'h4:    Out0 = 7'b0011001;
      4'h5:    Out0 = 7'b0010010;
      4'h6:    Out0 = 7'b0000010;
      4'h7:    Out0 = 7'b1111000;
      4'h8:    Out0 = 7'b0000000;
      4'h9:    Out0 = 7'b0010000;
      4'hA:    Out0 = 7'b0001000;
      4'hB:    Out0 = 7'b0000011;
      4'hC:    Out0 = 7'b1000110;
      4'hD:    Out0 = 7'b0100001;
      4'hE:    Out0 = 7'b0000110;
      4'hF:    Out0 = 7'b0001110;
      default: Out0 = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// Two-requester round-robin arbiter owning a 4-digit hex display; each grant
// holds the display for DWELL_CYCLES before the next request is considered.
module hex_display_arbiter
  import hex_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 32'd25_000_000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [15:0] data_a,
  input  logic [15:0] data_b,
  input  logic        blank_lz,
  output logic        ack_a,
  output logic        ack_b,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic        owner,
  output logic        busy
);

  localparam int            CW       = cnt_width(64'(DWELL_CYCLES));
  localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL_CYCLES - 32'd1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ack_a_q, ack_a_d;
  logic          ack_b_q, ack_b_d;
  logic          owner_q, owner_d;
  logic          ptr_q, ptr_d;
  logic          shown_q, shown_d;
  logic [15:0]   disp_q, disp_d;
  logic          grant_b_s;

  // Next-state: grants only from IDLE, pointer always moves to the loser.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ack_a_d   = 1'b0;
    ack_b_d   = 1'b0;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    shown_d   = shown_q;
    disp_d    = disp_q;
    grant_b_s = (req_a && req_b) ? ptr_q : req_b;
    case (state_q)
      ST_IDLE: begin
        if (req_a || req_b) begin
          disp_d  = grant_b_s ? data_b : data_a;
          owner_d = grant_b_s;
          ptr_d   = ~grant_b_s;
          shown_d = 1'b1;
          ack_a_d = ~grant_b_s;
          ack_b_d = grant_b_s;
          cnt_d   = CNT_LOAD;
          state_d = ST_DWELL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DWELL: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CW{1'b0}};
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      shown_q <= 1'b0;
      disp_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      shown_q <= shown_d;
      disp_q  <= disp_d;
    end
  end

  logic [6:0] seg_raw_s [4];
  logic [6:0] hex_s     [4];

  for (genvar g = 0; g < 4; g++) begin : g_hex
    HexDriver u_hex (
      .In0  (disp_q[4*g +: 4]),
      .Out0 (seg_raw_s[g])
    );
  end

  // Blanking after decode; digit 0 is never a leading zero.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      if (!shown_q) begin
        hex_s[n] = SEG_BLANK;
      end else if (blank_lz && (n != 0) && ((disp_q >> (4 * n)) == 16'h0000)) begin
        hex_s[n] = SEG_BLANK;
      end else begin
        hex_s[n] = seg_raw_s[n];
      end
    end
  end

  assign HEX0  = hex_s[0];
  assign HEX1  = hex_s[1];
  assign HEX2  = hex_s[2];
  assign HEX3  = hex_s[3];
  assign ack_a = ack_a_q;
  assign ack_b = ack_b_q;
  assign owner = owner_q;
  assign busy  = (state_q == ST_DWELL);

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Self-checking bench: directed vector table, corner-case sequences and
// random traffic against a time-based reference model.
module tb_hex_display_arbiter;

  localparam int DW = 4;

  logic        Clk;
  logic        Reset_n;
  logic        req_a, req_b;
  logic [15:0] data_a, data_b;
  logic        blank_lz;
  logic        ack_a, ack_b;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;
  logic        owner, busy;

  hex_display_arbiter #(.DWELL_CYCLES(DW)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .req_a    (req_a),
    .req_b    (req_b),
    .data_a   (data_a),
    .data_b   (data_b),
    .blank_lz (blank_lz),
    .ack_a    (ack_a),
    .ack_b    (ack_b),
    .HEX0     (HEX0),
    .HEX1     (HEX1),
    .HEX2     (HEX2),
    .HEX3     (HEX3),
    .owner    (owner),
    .busy     (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a grant is possible once the edge index reaches free_at.
  int          cyc = 0;
  int          free_at = 0;
  int          busy_until = 0;
  logic        m_ptr = 1'b0, m_owner = 1'b0, m_shown = 1'b0;
  logic        m_ack_a = 1'b0, m_ack_b = 1'b0;
  logic [15:0] m_disp = 16'h0000;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  localparam logic [27:0] BLANK4 = {7'h7F, 7'h7F, 7'h7F, 7'h7F};
  localparam logic [27:0] S_1A2F = {7'h79, 7'h08, 7'h24, 7'h0E};
  localparam logic [27:0] S_0030 = {7'h7F, 7'h7F, 7'h30, 7'h40};
  localparam logic [27:0] S_0000 = {7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [27:0] Z_0000 = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] S_BEEF = {7'h03, 7'h06, 7'h06, 7'h0E};

  function automatic logic [6:0] m_seg(input int n);
    logic [15:0] upper;
    upper = m_disp >> (4 * n);
    if (!m_shown) return 7'h7F;
    if (blank_lz && n > 0 && upper == 16'h0000) return 7'h7F;
    return glyph[upper[3:0]];
  endfunction

  function automatic logic [31:0] model_vec();
    return {m_ack_a, m_ack_b, (cyc < busy_until), m_owner,
            m_seg(3), m_seg(2), m_seg(1), m_seg(0)};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {ack_a, ack_b, busy, owner, HEX3, HEX2, HEX1, HEX0};
  endfunction

  function automatic void model_edge();
    logic pick_b;
    cyc++;
    m_ack_a = 1'b0;
    m_ack_b = 1'b0;
    if (!Reset_n) begin
      m_ptr = 1'b0; m_owner = 1'b0; m_shown = 1'b0; m_disp = 16'h0000;
      busy_until = 0; free_at = 0;
    end else if (cyc >= free_at && (req_a || req_b)) begin
      pick_b     = (req_a && req_b) ? m_ptr : req_b;
      m_disp     = pick_b ? data_b : data_a;
      m_owner    = pick_b;
      m_ptr      = ~pick_b;
      m_shown    = 1'b1;
      m_ack_a    = ~pick_b;
      m_ack_b    = pick_b;
      busy_until = cyc + DW;
      free_at    = cyc + DW + 1;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic apply(input logic rn, input logic ra, input logic rb,
                       input logic [15:0] da, input logic [15:0] db, input logic blz);
    Reset_n = rn; req_a = ra; req_b = rb; data_a = da; data_b = db; blank_lz = blz;
    @(posedge Clk);
    model_edge();
    @(negedge Clk);
    check("model", dut_vec(), model_vec());
  endtask

  typedef struct {
    logic        rn, ra, rb;
    logic [15:0] da, db;
    logic        blz;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic rn, input logic ra, input logic rb,
                              input logic [15:0] da, input logic [15:0] db, input logic blz,
                              input logic ea, input logic eb, input logic ebusy, input logic eown,
                              input logic [27:0] ehex);
    vec_t v;
    v.rn = rn; v.ra = ra; v.rb = rb; v.da = da; v.db = db; v.blz = blz;
    v.exp = {ea, eb, ebusy, eown, ehex};
    return v;
  endfunction

  initial begin
    vec_t tbl[$];
    int   ack_cyc[$];
    logic ack_src[$];
    logic seen_b;

    Reset_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
    data_a = 16'h0000; data_b = 16'h0000; blank_lz = 1'b0;

    // Reset followed by ten idle cycles.
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 10; i++) apply(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    check("idle_state", dut_vec(), {4'b0000, BLANK4});

    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, BLANK4));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, BLANK4));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, BLANK4));
    tbl.push_back(mk(1, 1, 0, 16'h1A2F, 16'h0000, 0, 1, 0, 1, 0, S_1A2F));
    tbl.push_back(mk(1, 0, 0, 16'h1A2F, 16'h0000, 0, 0, 0, 1, 0, S_1A2F));
    tbl.push_back(mk(1, 0, 0, 16'h1A2F, 16'h0000, 0, 0, 0, 1, 0, S_1A2F));
    tbl.push_back(mk(1, 0, 0, 16'h1A2F, 16'h0000, 0, 0, 0, 1, 0, S_1A2F));
    tbl.push_back(mk(1, 0, 0, 16'h1A2F, 16'h0000, 0, 0, 0, 0, 0, S_1A2F));
    tbl.push_back(mk(1, 0, 1, 16'h0000, 16'h0030, 1, 0, 1, 1, 1, S_0030));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0030, 1, 0, 0, 1, 1, S_0030));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0030, 1, 0, 0, 1, 1, S_0030));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0030, 1, 0, 0, 1, 1, S_0030));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0030, 1, 0, 0, 0, 1, S_0030));
    tbl.push_back(mk(1, 0, 1, 16'h0000, 16'h0000, 1, 0, 1, 1, 1, S_0000));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 1, 1, S_0000));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, Z_0000));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 1, 1, S_0000));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 1, S_0000));

    foreach (tbl[i]) begin
      apply(tbl[i].rn, tbl[i].ra, tbl[i].rb, tbl[i].da, tbl[i].db, tbl[i].blz);
      check($sformatf("vec%0d", i), dut_vec(), tbl[i].exp);
    end

    // Both requesters held: alternate A, B, A, B at five-cycle spacing.
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    for (int i = 0; i < 21; i++) begin
      apply(1'b1, 1'b1, 1'b1, 16'hAAAA, 16'hBBBB, 1'b0);
      if (ack_a || ack_b) begin
        ack_cyc.push_back(cyc);
        ack_src.push_back(ack_b);
      end
    end
    check("rr_count", 32'(ack_cyc.size()), 32'd5);
    for (int i = 0; i < ack_cyc.size() && i < 5; i++) begin
      check($sformatf("rr_src%0d", i), {31'd0, ack_src[i]}, 32'(i % 2));
      if (i > 0) check($sformatf("rr_gap%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd5);
    end

    // A req_b pulse inside the dwell window must be ignored.
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 16'hBEEF, 16'h0000, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 16'hBEEF, 16'h1234, 1'b0);
    seen_b = ack_b;
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, 1'b0, 1'b0, 16'hBEEF, 16'h1234, 1'b0);
      seen_b = seen_b | ack_b;
    end
    check("no_ack_b", {31'd0, seen_b}, 32'd0);
    check("beef_held", {4'd0, HEX3, HEX2, HEX1, HEX0}, {4'd0, S_BEEF});

    // Reset during the second dwell cycle, req_a pending across it.
    apply(1'b1, 1'b1, 1'b0, 16'hC0DE, 16'h0000, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 16'hC0DE, 16'h0000, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 16'hC0DE, 16'h0000, 1'b0);
    check("abort_dwell", dut_vec(), {4'b0000, BLANK4});
    apply(1'b1, 1'b1, 1'b0, 16'hC0DE, 16'h0000, 1'b0);
    check("regrant_a", {28'd0, ack_a, ack_b, busy, owner}, 32'b1010);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_display_arbiter.md
HEX_DISPLAY_ARBITER -- requirements
Module: hex_display_arbiter

Interface
REQ-001 The block SHALL have the parameter DWELL_CYCLES, default 25_000_000: minimum number of cycles a granted value stays displayed (legal range 1 to 2^32-1).
REQ-002 The block SHALL have the port Clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port Reset_n, input, width 1: reset, synchronous and active-low.
REQ-004 The block SHALL have the ports req_a / req_b, input, width 1: display request from requester A or B.
REQ-005 The block SHALL have the ports data_a / data_b, input, width 16: value to display, as 4 hex nibbles.
REQ-006 The block SHALL have the ports ack_a / ack_b, output, width 1: one-cycle grant/accept pulse to requester A or B.
REQ-007 The block SHALL have the port blank_lz, input, width 1: when 1, leading-zero digits are blanked.
REQ-008 The block SHALL have the ports HEX0..HEX3, output, width 7 each: active-low segments, HEX0 = least significant nibble.
REQ-009 The block SHALL have the port owner, output, width 1: source of the displayed value (0 = A, 1 = B).
REQ-010 The block SHALL have the port busy, output, width 1: high while in DWELL.

Function
REQ-011 The FSM SHALL have two states: IDLE and DWELL.
REQ-012 In IDLE with exactly one req high, the block SHALL grant that requester on the next edge.
REQ-013 In IDLE with both req high, the block SHALL grant the requester selected by the round-robin pointer, then point the pointer at the other requester.
REQ-014 A single-requester grant SHALL also set the pointer to the requester not granted.
REQ-015 On the grant edge, the block SHALL latch data_x into a 16-bit display register, set owner, set a shown flag, pulse ack_x high for exactly one cycle, load the dwell counter with DWELL_CYCLES-1, and enter DWELL.
REQ-016 In DWELL, the block SHALL ignore req_a and req_b and hold ack_a = ack_b = 0.
REQ-017 In DWELL, when the counter = 0 the block SHALL go to IDLE; otherwise it SHALL decrement the counter.
REQ-018 DWELL SHALL last exactly DWELL_CYCLES cycles, and consecutive acks SHALL be at least DWELL_CYCLES+1 cycles apart.
REQ-019 Requesters SHALL hold req and data stable until ack; a req dropped before it is sampled in IDLE SHALL produce no grant and no display change.
REQ-020 busy SHALL be 1 exactly when the state is DWELL.
REQ-021 HEXn SHALL be the hex-digit segment decode (0-F, standard 0-9, A, b, C, d, E, F glyphs) of display register nibble n, combinational from registered state, so the new value is visible in the same cycle ack is high.
REQ-022 While the shown flag = 0, all HEXn SHALL be 7'b1111111.
REQ-023 With blank_lz = 1, HEXn for n ≥ 1 SHALL be 7'b1111111 when nibbles 3..n are all zero; HEX0 SHALL never be blanked, so value 0x0000 shows "0".
REQ-024 blank_lz SHALL take effect combinationally, without affecting the FSM.
REQ-025 The display register SHALL change only on a grant edge.

Reset
REQ-026 When Reset_n = 0 at a rising edge, the block SHALL set state IDLE, counter 0, ack_a = ack_b = 0, owner 0, busy 0, pointer = A, shown flag 0, and display register 0x0000.
REQ-027 Per REQ-026, all HEXn SHALL read 7'b1111111 after reset.
REQ-028 A reset asserted mid-DWELL SHALL abort the dwell immediately.
REQ-029 After reset, the first IDLE cycle with Reset_n = 1 SHALL sample requests normally.

Structure
REQ-030 Package hex_pkg SHALL hold the state enum typedef and the constant SEG_BLANK = 7'b1111111.
REQ-031 The dwell counter width SHALL be $clog2(DWELL_CYCLES+1), minimum 1.
REQ-032 The block SHALL use four instances of the existing HexDriver sub-module for the nibble-to-segment decode, with blanking muxed after them; no other sub-module.

Verification (bench SHALL use DWELL_CYCLES = 4)
REQ-033 Reset, then idle 10 cycles -> all HEXn = 7'h7F, ack_a = ack_b = 0, busy = 0.
REQ-034 req_a = 1, data_a = 16'h1A2F held until ack -> one-cycle ack_a; HEX3..HEX0 = 1, A, 2, F (7'b1111001, 7'b0001000, 7'b0100100, 7'b0001110); owner = 0; busy high for 4 cycles.
REQ-035 req_a and req_b held high continuously after reset -> grant order A, B, A, B; acks exactly 5 cycles apart; owner alternates.
REQ-036 blank_lz = 1, data_b = 16'h0030 -> HEX3 and HEX2 blank, HEX1 = 3, HEX0 = 0; with data 16'h0000 -> only HEX0 = 0 shown.
REQ-037 req_b pulsed high for 1 cycle during DWELL and dropped before IDLE -> no ack_b and display unchanged.
REQ-038 Reset_n low for 1 cycle during the 2nd DWELL cycle -> next cycle busy = 0, all HEXn blank, and a pending req_a is granted in the following IDLE cycle.
